sccb_cfg_seq: RTL
=================

// Module: sccb_cfg_seq
// PURPOSE
//  Camera register-init sequencer sitting directly upstream of sccb_fsm. On start (or after
//  reset) it waits a power-up delay, then walks a constant table of {verify, addr, data} entries.
//  Each entry becomes one SCCB write command; when the verify bit is set it is followed by a
//  read-back compare, retried on mismatch. Reports completion or the failing table index.
// PARAMETERS
//  ADDR_WIDTH      8      register address width (matches sccb_fsm)
//  DATA_WIDTH      8      register data width (matches sccb_fsm)
//  IDX_WIDTH       6      table index width; table depth = 2**IDX_WIDTH
//  POWERUP_CYCLES  20000  clk cycles from start to the first command
//  GAP_CYCLES      4      idle clk cycles after each sccb_done before the next sccb_valid
//  MAX_RETRY       3      extra attempts per verified entry before error
// PORTS
//  clk         in   1    system clock
//  rst         in   1    synchronous, active-high reset
//  start       in   1    1-cycle pulse: restart sequence from index 0 (ignored while busy)
//  busy        out  1    high from sequence start until cfg_done or cfg_error
//  cfg_done    out  1    level: whole table written (and verified) OK
//  cfg_error   out  1    level: an entry failed verification after MAX_RETRY retries
//  err_index   out  IDX  table index of the failing entry; valid while cfg_error
//  sccb_valid  out  1    1-cycle command strobe to sccb_fsm valid_in
//  sccb_write  out  1    to sccb_fsm write: 0 = write transaction, 1 = read transaction
//  sccb_addr   out  ADDR register address, stable from sccb_valid until sccb_done
//  sccb_data   out  DATA write data, stable from sccb_valid until sccb_done
//  sccb_done   in   1    1-cycle end-of-transaction pulse from sccb_fsm
//  sccb_rdata  in   DATA read data from sccb_fsm, sampled in the sccb_done cycle
// BEHAVIOUR
//  Reset: state PWRUP (auto-start), busy=1, cfg_done=0, cfg_error=0, err_index=0,
//    sccb_valid=0, sccb_write=0, sccb_addr=0, sccb_data=0, index=0, retry=0.
//  States: IDLE, PWRUP, FETCH, ISSUE_W, WAIT_W, GAP_W, ISSUE_R, WAIT_R, CHECK, GAP_R, DONE, ERROR.
//  IDLE: start -> PWRUP (clear cfg_done/cfg_error, index=0, busy=1).
//  PWRUP: count POWERUP_CYCLES -> FETCH.
//  FETCH: read ROM entry[index] (combinational). addr==8'hFF && data==8'hFF is end marker -> DONE.
//    Otherwise latch sccb_addr/sccb_data/verify -> ISSUE_W.
//  ISSUE_W: sccb_valid=1 for exactly one cycle, sccb_write=0 -> WAIT_W.
//  WAIT_W: hold until sccb_done -> GAP_W.
//  GAP_W: wait GAP_CYCLES. If verify -> ISSUE_R; else index+1, retry=0 -> FETCH.
//  ISSUE_R: one-cycle sccb_valid, sccb_write=1 -> WAIT_R. WAIT_R: on sccb_done capture rdata -> CHECK.
//  CHECK: rdata==sccb_data -> index+1, retry=0, GAP_R then FETCH.
//    Mismatch with retry<MAX_RETRY -> retry+1, GAP_R then ISSUE_W.
//    Mismatch with retry==MAX_RETRY -> err_index=index -> ERROR.
//  DONE: cfg_done=1, busy=0; ERROR: cfg_error=1, busy=0. Both return to IDLE-like
//    waiting: start restarts from PWRUP.
//  sccb_fsm has no NACK output; a NACKed write is only detected via read-back.
//  Never assert sccb_valid within GAP_CYCLES (>=2) of sccb_done: sccb_fsm gives valid_in priority
//    over done, and needs one idle cycle to reload its shift register.
//  Index wraps: an index reaching 2**IDX_WIDTH-1 without an end marker -> DONE after that entry.
//  start while busy: ignored. sccb_done outside WAIT_W/WAIT_R: ignored.
//  rst mid-transaction: sequencer restarts at PWRUP; sccb_fsm must be reset on the same rst.
//  All counters are sized by $clog2 of their parameter; no overflow is allowed.
// STRUCTURE
//  Shared package sccb_pkg: state encoding localparams, END_ADDR=8'hFF, END_DATA=8'hFF,
//    ENTRY_WIDTH=1+ADDR_WIDTH+DATA_WIDTH, SCCB_WR=1'b0, SCCB_RD=1'b1.
//  Sub-module sccb_cfg_rom: combinational case table, index -> {verify, addr, data},
//    OV7725 defaults. The first entry is 12h=80h (soft reset) with verify=0.
//  Top: FSM, delay/gap counter, retry counter, index register.
// TESTING
//  Reset with POWERUP_CYCLES=16: first sccb_valid at cycle 16+1 after rst release, sccb_write=0,
//    addr=12h, data=80h.
//  Model ACKs and echoes writes; 3-entry table + end marker -> exactly 3 writes plus reads for
//    verified entries; then cfg_done=1, busy=0, no further sccb_valid.
//  Model returns 00h for addr 11h (expects 01h), MAX_RETRY=3 -> 4 writes and 4 reads of 11h,
//    then cfg_error=1 and err_index = index of 11h.
//  Mismatch once then correct -> one retry; sequence continues and cfg_done=1.
//  Check spacing: each sccb_valid is >=GAP_CYCLES after the previous sccb_done, and addr/data
//    stay stable throughout.
//  Assert rst during WAIT_R: all outputs return to reset values; a start pulse while busy is
//    ignored; after DONE, a start pulse reruns the full table.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB register-init sequencer: FSM states, end marker,
// table entry layout and transaction direction codes.
package sccb_pkg;

    localparam int SCCB_ADDR_W = 8;
    localparam int SCCB_DATA_W = 8;
    localparam int ENTRY_WIDTH = 1 + SCCB_ADDR_W + SCCB_DATA_W;

    localparam logic [7:0] END_ADDR = 8'hFF;
    localparam logic [7:0] END_DATA = 8'hFF;

    localparam logic SCCB_WR = 1'b0;
    localparam logic SCCB_RD = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        PWRUP,
        FETCH,
        ISSUE_W,
        WAIT_W,
        GAP_W,
        ISSUE_R,
        WAIT_R,
        CHECK,
        GAP_R,
        DONE,
        ERROR
    } seq_state_t;

endpackage

// File: rtl/sccb_cfg_seq_if.sv
// Command/response bundle between the init sequencer (master) and sccb_fsm (slave).
interface sccb_cfg_seq_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) ();

    logic                  sccb_valid;
    logic                  sccb_write;
    logic [ADDR_WIDTH-1:0] sccb_addr;
    logic [DATA_WIDTH-1:0] sccb_data;
    logic                  sccb_done;
    logic [DATA_WIDTH-1:0] sccb_rdata;

    modport master (
        output sccb_valid, sccb_write, sccb_addr, sccb_data,
        input  sccb_done, sccb_rdata
    );

    modport slave (
        input  sccb_valid, sccb_write, sccb_addr, sccb_data,
        output sccb_done, sccb_rdata
    );

endinterface

// File: rtl/sccb_cfg_rom.sv
// Constant OV7725 init table: index -> {verify, addr, data}; unused slots hold the end marker.
module sccb_cfg_rom
    import sccb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = 6
) (
    input  logic [IDX_WIDTH-1:0]  index,
    output logic                  verify,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    always_comb begin
        verify = 1'b0;
        addr   = ADDR_WIDTH'(END_ADDR);
        data   = DATA_WIDTH'(END_DATA);
        case (index)
            // Soft reset self-clears, so it cannot be read back.
            IDX_WIDTH'(0): {verify, addr, data} = {1'b0, ADDR_WIDTH'(8'h12), DATA_WIDTH'(8'h80)};
            IDX_WIDTH'(1): {verify, addr, data} = {1'b1, ADDR_WIDTH'(8'h11), DATA_WIDTH'(8'h01)};
            IDX_WIDTH'(2): {verify, addr, data} = {1'b1, ADDR_WIDTH'(8'h0C), DATA_WIDTH'(8'h10)};
            default: ;
        endcase
    end

endmodule

// File: rtl/sccb_cfg_seq.sv
// Camera register-init sequencer: power-up delay, then one SCCB write per table entry,
// with optional read-back verify and bounded retry.
module sccb_cfg_seq
    import sccb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int IDX_WIDTH      = 6,
    parameter int POWERUP_CYCLES = 20000,
    parameter int GAP_CYCLES     = 4,
    parameter int MAX_RETRY      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 cfg_done,
    output logic                 cfg_error,
    output logic [IDX_WIDTH-1:0] err_index,
    sccb_cfg_seq_if.master       bus
);

    localparam int CNT_MAX = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [IDX_WIDTH-1:0] IDX_LAST = '1;

    seq_state_t            state;
    logic [CNT_W-1:0]      cnt;
    logic [RTY_W-1:0]      retry;
    logic [IDX_WIDTH-1:0]  index;
    logic                  verify_q;
    logic                  adv_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  rom_verify;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;

    sccb_cfg_rom #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_rom (
        .index  (index),
        .verify (rom_verify),
        .addr   (rom_addr),
        .data   (rom_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= PWRUP;
            busy           <= 1'b1;
            cfg_done       <= 1'b0;
            cfg_error      <= 1'b0;
            err_index      <= '0;
            bus.sccb_valid <= 1'b0;
            bus.sccb_write <= SCCB_WR;
            bus.sccb_addr  <= '0;
            bus.sccb_data  <= '0;
            index          <= '0;
            retry          <= '0;
            cnt            <= '0;
            verify_q       <= 1'b0;
            adv_q          <= 1'b0;
            rdata_q        <= '0;
        end else begin
            bus.sccb_valid <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state     <= PWRUP;
                        busy      <= 1'b1;
                        cfg_done  <= 1'b0;
                        cfg_error <= 1'b0;
                        index     <= '0;
                        retry     <= '0;
                        cnt       <= '0;
                    end
                end
                PWRUP: begin
                    if (cnt == CNT_W'(POWERUP_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= FETCH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FETCH: begin
                    if (rom_addr == ADDR_WIDTH'(END_ADDR) && rom_data == DATA_WIDTH'(END_DATA)) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        cfg_done <= 1'b1;
                    end else begin
                        bus.sccb_addr  <= rom_addr;
                        bus.sccb_data  <= rom_data;
                        verify_q       <= rom_verify;
                        bus.sccb_write <= SCCB_WR;
                        bus.sccb_valid <= 1'b1;
                        state          <= ISSUE_W;
                    end
                end
                ISSUE_W: state <= WAIT_W;
                WAIT_W: begin
                    if (bus.sccb_done) begin
                        cnt   <= '0;
                        state <= GAP_W;
                    end
                end
                GAP_W: begin
                    if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt <= '0;
                        if (verify_q) begin
                            bus.sccb_write <= SCCB_RD;
                            bus.sccb_valid <= 1'b1;
                            state          <= ISSUE_R;
                        end else if (index == IDX_LAST) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            cfg_done <= 1'b1;
                        end else begin
                            index <= index + 1'b1;
                            retry <= '0;
                            state <= FETCH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ISSUE_R: state <= WAIT_R;
                WAIT_R: begin
                    if (bus.sccb_done) begin
                        rdata_q <= bus.sccb_rdata;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    cnt <= '0;
                    if (rdata_q == bus.sccb_data) begin
                        adv_q <= 1'b1;
                        retry <= '0;
                        state <= GAP_R;
                    end else if (retry == RTY_W'(MAX_RETRY)) begin
                        err_index <= index;
                        cfg_error <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ERROR;
                    end else begin
                        adv_q <= 1'b0;
                        retry <= retry + 1'b1;
                        state <= GAP_R;
                    end
                end
                GAP_R: begin
                    if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt <= '0;
                        if (!adv_q) begin
                            // Verify failed: rewrite the same entry.
                            bus.sccb_write <= SCCB_WR;
                            bus.sccb_valid <= 1'b1;
                            state          <= ISSUE_W;
                        end else if (index == IDX_LAST) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            cfg_done <= 1'b1;
                        end else begin
                            index <= index + 1'b1;
                            state <= FETCH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= PWRUP;
            endcase
        end
    end

endmodule
